// File: rtl/cpu_fsm.sv
// Controller for a simple load/store datapath: decodes a latched IR and sequences register-file/ALU strobes.
// Latency: MOV imm 2, MOV reg/CMP 4, ADD/AND/MVN 5 cycles from start to idle; outputs are Moore.
// Backpressure: none, s is level-sensitive and load is honoured only while idle; CPU_FSM_ILLEGAL_TRAP_EN adds HALT.
module cpu_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [3:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_EXEC      = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    localparam logic [2:0] S_HALT      = 3'd7;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        ir_d = ir_q;
        if ((state_q == S_WAIT) && load) begin
            ir_d = in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:      state_d = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WRITE_IMM;
                end else if (is_mov_reg) begin
                    state_d = S_GET_B;
                end else if (is_alu) begin
                    state_d = S_GET_A;
                end else begin
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            // Only reset leaves HALT.
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 4'b0000;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 4'b0100;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                loadc = 1'b1;
                // MOV reg passes B through the ALU by zeroing the A operand.
                asel  = is_mov_reg;
                ALUop = is_alu ? op : 2'b00;
                loads = is_cmp;
            end
            S_WRITE_REG: begin
                writenum = rd;
                vsel     = 4'b0001;
                write    = 1'b1;
            end
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            S_HALT: err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_fsm.sv
// Randomized bench for cpu_fsm: an instruction-level model lists the expected control record for each cycle.
module tb_cpu_fsm;

    logic        clk = 1'b0;
    logic        reset_n, s, load;
    logic [15:0] in;
    logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;

    cpu_fsm dut (
        .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in),
        .w(w), .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Record layout: w, err, readnum, writenum, {write,loada,loadb,loadc,loads,asel,bsel}, vsel, shift, ALUop
    logic [22:0] obs;
    assign obs = {w, err, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop};

    function automatic logic [22:0] rec(input logic w_, input logic e_, input logic [2:0] rn_,
                                        input logic [2:0] wn_, input logic [6:0] stb,
                                        input logic [3:0] vs, input logic [1:0] sh_, input logic [1:0] alu);
        return {w_, e_, rn_, wn_, stb, vs, sh_, alu};
    endfunction

    localparam logic [6:0] ST_WRITE = 7'b1000000;
    localparam logic [6:0] ST_LDA   = 7'b0100000;
    localparam logic [6:0] ST_LDB   = 7'b0010000;
    localparam logic [6:0] ST_LDC   = 7'b0001000;
    localparam logic [6:0] ST_LDS   = 7'b0000100;
    localparam logic [6:0] ST_ASEL  = 7'b0000010;

    logic [22:0] idle_r, busy_r, halt_r;
    logic [22:0] exp_q[$];

    function automatic bit is_legal(input logic [15:0] ir);
        return (ir[15:13] == 3'b101) || (ir[15:13] == 3'b110 && (ir[12:11] == 2'b10 || ir[12:11] == 2'b00));
    endfunction

    // Per-cycle control records after the start edge, derived from the instruction's class.
    function automatic void build(input logic [15:0] ir);
        logic [2:0] rn_, rd_, rm_;
        logic [1:0] op_, sh_;
        bit cmp;
        rn_ = ir[10:8]; rd_ = ir[7:5]; rm_ = ir[2:0]; op_ = ir[12:11]; sh_ = ir[4:3];
        exp_q.delete();
        exp_q.push_back(busy_r);
        if (!is_legal(ir)) return;
        if (ir[15:13] == 3'b110 && op_ == 2'b10) begin
            exp_q.push_back(rec(0, 0, 0, rn_, ST_WRITE, 4'b0100, 0, 0));
            return;
        end
        cmp = (ir[15:13] == 3'b101) && (op_ == 2'b01);
        if (ir[15:13] == 3'b101) exp_q.push_back(rec(0, 0, rn_, 0, ST_LDA, 0, 0, 0));
        exp_q.push_back(rec(0, 0, rm_, 0, ST_LDB, 0, 0, 0));
        if (ir[15:13] == 3'b110)
            exp_q.push_back(rec(0, 0, 0, 0, ST_LDC | ST_ASEL, 0, sh_, 2'b00));
        else
            exp_q.push_back(rec(0, 0, 0, 0, ST_LDC | (cmp ? ST_LDS : 7'b0), 0, sh_, op_));
        if (!cmp) exp_q.push_back(rec(0, 0, 0, rd_, ST_WRITE, 4'b0001, 0, 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outputs", 32'(obs), 32'(idle_r));
        chk("reset_ir", 32'(sximm8), 32'h0);
        #2 reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [15:0] ir);
        logic [15:0] x8, x5;
        x8 = {{8{ir[7]}}, ir[7:0]};
        x5 = {{11{ir[4]}}, ir[4:0]};
        load = 1'b1; in = ir; s = 1'b0;
        tick();
        load = 1'b0;
        chk($sformatf("sximm8 ir=%h", ir), 32'(sximm8), 32'(x8));
        chk($sformatf("sximm5 ir=%h", ir), 32'(sximm5), 32'(x5));
        chk($sformatf("idle ir=%h", ir), 32'(obs), 32'(idle_r));
        s = 1'b1;
        tick();
        s = 1'b0;
        load = 1'b1; in = 16'($urandom);
        build(ir);
        foreach (exp_q[i]) begin
            chk($sformatf("cycle%0d ir=%h", i + 1, ir), 32'(obs), 32'(exp_q[i]));
            tick();
        end
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        if (!is_legal(ir)) begin
            for (int k = 0; k < 10; k++) begin
                s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
                chk($sformatf("halt%0d ir=%h", k, ir), 32'(obs), 32'(halt_r));
                tick();
            end
            s = 1'b0; load = 1'b0;
            do_reset();
            return;
        end
`endif
        chk($sformatf("done ir=%h", ir), 32'(obs), 32'(idle_r));
        chk($sformatf("ir_kept ir=%h", ir), 32'(sximm8), 32'(x8));
        load = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 5))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3, 4: r[15:13] = 3'b101;
            default: while (is_legal(r)) r = 16'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        idle_r = rec(1, 0, 0, 0, 0, 0, 0, 0);
        busy_r = rec(0, 0, 0, 0, 0, 0, 0, 0);
        halt_r = rec(0, 1, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;
        #1;
        chk("por_outputs", 32'(obs), 32'(idle_r));
        chk("por_ir", 32'({sximm8, sximm5}), 32'h0);
        #12 reset_n = 1'b1;

        run_instr(16'hD007);
        run_instr(16'hD1FE);
        run_instr(16'hA148);
        run_instr(16'hA900);

        // Reset pulled during GET_B of an ADD.
        load = 1'b1; in = 16'hA148;
        tick();
        load = 1'b0; s = 1'b1;
        tick();
        s = 1'b0;
        tick();
        tick();
        chk("get_b_before_reset", 32'(obs), 32'(rec(0, 0, 0, 0, ST_LDB, 0, 0, 0)));
        do_reset();
        chk("ir_after_release", 32'(sximm8), 32'h0);
        run_instr(16'hD007);

        // Level-sensitive start: holding s reissues the same IR.
        load = 1'b1; in = 16'hD305;
        tick();
        load = 1'b0; s = 1'b1;
        tick();
        tick();
        tick();
        chk("hold_s_wait", 32'(obs), 32'(idle_r));
        tick();
        chk("hold_s_restart", 32'(obs), 32'(busy_r));
        s = 1'b0;
        tick();
        chk("hold_s_write", 32'(obs), 32'(rec(0, 0, 0, 3'd3, ST_WRITE, 4'b0100, 0, 0)));
        tick();
        chk("hold_s_done", 32'(obs), 32'(idle_r));

        run_instr(16'h0000);

        for (int t = 0; t < 80; t++) run_instr(rand_instr());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
